range_frame_tx: RTL
===================

# range_frame_tx

Transmit side of the go/finish framed sample protocol consumed by the range-finder chip. A host loads up to `DEPTH` samples into an internal buffer. On `send`, the block replays them as one frame: a `go` cycle, one sample per cycle, and `finish` on the last sample, followed by a guard cycle. It also computes the expected range (max − min) of the loaded samples, so a bench or on-chip checker can compare it against the receiver's output during `finish`.

## Interface
Parameters:
- `DATA_W`, 12, sample width.
- `DEPTH`, 8, buffer capacity in samples; a power of two, at least 2.

Ports:
- `clock`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `wr_valid`  in  1  host presents a sample.
- `wr_data`  in  DATA_W  sample value.
- `wr_ready`  out  1  buffer accepts a write this cycle.
- `send`  in  1  request frame transmission; level sampled, acted on only in IDLE.
- `busy`  out  1  frame in progress, from GO through GUARD.
- `data_out`  out  DATA_W  sample stream to the receiver.
- `go`  out  1  frame start strobe.
- `finish`  out  1  last-sample strobe.
- `done`  out  1  one-cycle pulse in the guard cycle.
- `send_err`  out  1  one-cycle pulse: `send` issued with an empty buffer.
- `exp_range`  out  DATA_W  max − min of the last transmitted frame.

## Operation
- States: IDLE, GO, STREAM, GUARD. State, index, count, buffer, max/min and all outputs are registered.
- IDLE
  - A write is accepted when `wr_valid && wr_ready`.
  - `wr_ready` = (state == IDLE) && (count < DEPTH).
  - An accepted sample goes to `buf[count]`; count increments; running max and min update.
- IDLE → GO on `send` with count > 0.
  - `send` with count == 0 pulses `send_err` for the next cycle and stays in IDLE.
  - A write and `send` in the same IDLE cycle: the write is accepted and included in the frame.
- GO, one cycle: `go`=1, `finish`=0, `data_out`=0. idx is set to 0.
- STREAM, count cycles: `data_out`=`buf[idx]`; idx increments each cycle.
  - `finish`=1 only on the cycle with idx == count−1; STREAM then moves to GUARD.
  - count == 1: exactly one STREAM cycle, with `finish`=1.
- GUARD, one cycle: `done`=1, `data_out`=0, strobes low.
  - Buffer is cleared: count=0, max=0, min=all ones. The next state is IDLE.
  - The guard cycle matches the receiver's ending state, so back-to-back frames never overlap.
- `exp_range` is updated on the `finish` cycle to running max − running min.
  - Arithmetic is unsigned DATA_W; the result is non-negative, so no overflow.
  - It holds until the next frame's `finish`.
- `busy` is high in GO, STREAM and GUARD.
- `send`, `wr_valid` and `send_err` generation are ignored while busy.
- `go` and `finish` are never high together.

## Timing
- Reset values:
  - `wr_ready`=1; `busy`, `go`, `finish`, `done`, `send_err`, `data_out`, `exp_range` = 0.
  - State IDLE, count 0, max 0, min all ones.
- Latency and frame length:
  - `send` sampled at edge k → `go` high in cycle k+1.
  - First sample is in cycle k+2; `finish` is in cycle k+1+count; `done` is in cycle k+2+count.
  - `busy` spans count+2 cycles.
- Next frame: the earliest next `go` is 2 cycles after `done`. One cycle is needed to reload at least one sample, plus the `send` edge.
- Reset mid-frame:
  - All outputs drop to their reset values asynchronously and the buffer is emptied.
  - No `finish` or `done` is emitted for the aborted frame.
- A full buffer (count == DEPTH) drops `wr_ready`. Writes attempted while `wr_ready`=0 are discarded.

## Structure
- Package `range_pkg`:
  - `range_tx_state_t` enum {IDLE, GO, STREAM, GUARD}.
  - The `DATA_W` default constant, shared with the receiver.
- Sub-module `range_sample_buf` holds the storage array, count, and running max/min registers.
  - Ports: `wr_en`, `wr_data`, `clear`, `rd_idx`, `rd_data`, `count`, `full`, `max`, `min`.
- The top module holds the FSM, idx counter, strobe generation and `exp_range` register.

## Test plan
- Load 5, 20, 3, 17 then `send` → `go` at k+1; data 5, 20, 3, 17 in k+2..k+5; `finish` at k+5; `exp_range`=17; `done` at k+6.
- Load single sample 0xABC, `send` → one STREAM cycle with `data_out`=0xABC and `finish`=1; `exp_range`=0; `busy` lasts 3 cycles.
- Write 9 samples 1..9 with DEPTH=8 → `wr_ready` low after 8 writes; the 9th is dropped; frame streams 1..8; `exp_range`=7.
- `send` with an empty buffer → `send_err` pulses once; `go` never asserts; state stays IDLE.
- Assert `wr_valid` and `send` during STREAM → no write accepted, no restart; after `done`, count=0 and `wr_ready`=1.
- Assert `reset` on the 2nd STREAM cycle of a 4-sample frame → outputs 0 immediately, no `finish`/`done`; a new load of 0xFFF, 0x000 gives `exp_range`=0xFFF.

Source files
------------

// File: rtl/range_pkg.sv
// Shared types and defaults for the range-finder framed sample protocol.
package range_pkg;

    // Sample width shared by the transmitter and the range-finder receiver.
    localparam int unsigned RANGE_DATA_W = 12;

    // Default transmit buffer capacity in samples.
    localparam int unsigned RANGE_DEPTH = 8;

    // Transmit frame sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        GO,
        STREAM,
        GUARD
    } range_tx_state_t;

endpackage

// File: rtl/range_frame_tx_if.sv
// Host load port and frame output bundle of the range frame transmitter.
interface range_frame_tx_if import range_pkg::*; #(
    parameter int unsigned DATA_W = RANGE_DATA_W
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              send;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              go;
    logic              finish;
    logic              done;
    logic              send_err;
    logic [DATA_W-1:0] exp_range;

    // Host / bench side: loads samples, requests frames, observes the stream.
    modport master (
        output wr_valid, wr_data, send,
        input  wr_ready, busy, data_out, go, finish, done, send_err, exp_range
    );

    // Transmitter side.
    modport slave (
        input  wr_valid, wr_data, send,
        output wr_ready, busy, data_out, go, finish, done, send_err, exp_range
    );
endinterface

// File: rtl/range_sample_buf.sv
// Sample storage for one frame plus fill count and running max/min.
module range_sample_buf import range_pkg::*; #(
    parameter  int unsigned DATA_W = RANGE_DATA_W,
    parameter  int unsigned DEPTH  = RANGE_DEPTH,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = IDX_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic [DATA_W-1:0] max,
    output logic [DATA_W-1:0] min
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic              w_wr;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign w_wr    = wr_en && !full;
    assign count   = r_count;
    assign max     = r_max;
    assign min     = r_min;
    assign rd_data = r_mem[rd_idx];

    // Sample array; contents are meaningless beyond count, so no reset.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_count[IDX_W-1:0]] <= wr_data;
        end
    end

    // Fill count and running extremes; clear empties the buffer for the next frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_max   <= '0;
            r_min   <= '1;
        end else if (clear) begin
            r_count <= '0;
            r_max   <= '0;
            r_min   <= '1;
        end else if (w_wr) begin
            r_count <= r_count + CNT_W'(1);
            if (wr_data > r_max) begin
                r_max <= wr_data;
            end
            if (wr_data < r_min) begin
                r_min <= wr_data;
            end
        end
    end
endmodule

// File: rtl/range_frame_tx.sv
// Replays the loaded samples as one go/stream/finish/guard frame and
// reports the expected range (max - min) of that frame.
module range_frame_tx import range_pkg::*; #(
    parameter  int unsigned DATA_W = RANGE_DATA_W,
    parameter  int unsigned DEPTH  = RANGE_DEPTH,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = IDX_W + 1
) (
    input  logic            clock,
    input  logic            reset,
    range_frame_tx_if.slave bus
);
    range_tx_state_t   r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_wr_ready;
    logic              r_busy;
    logic [DATA_W-1:0] r_data_out;
    logic              r_go;
    logic              r_finish;
    logic              r_done;
    logic              r_send_err;
    logic [DATA_W-1:0] r_exp_range;

    logic              w_wr_en;
    logic              w_clear;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_last;
    logic              w_full;
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_min;
    logic [DATA_W-1:0] w_range;
    logic              w_has_data;
    logic              w_idx_is_last;
    logic              w_next_is_last;
    logic              w_fill_to_full;

    // r_wr_ready is only ever high in IDLE, so it alone qualifies a write.
    assign w_wr_en        = bus.wr_valid && r_wr_ready;
    assign w_clear        = (r_state == GUARD);
    assign w_last         = w_count - CNT_W'(1);
    assign w_range        = w_max - w_min;
    assign w_has_data     = (w_count != '0) || w_wr_en;
    // r_idx is the index of the sample currently on data_out; the buffer
    // is read one ahead so the next sample can be registered.
    assign w_rd_idx       = (r_state == STREAM) ? r_idx + IDX_W'(1) : '0;
    assign w_idx_is_last  = ({1'b0, r_idx} == w_last);
    assign w_next_is_last = ({1'b0, w_rd_idx} == w_last);
    assign w_fill_to_full = w_wr_en && (w_count == CNT_W'(DEPTH - 1));

    range_sample_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (w_wr_en),
        .wr_data (bus.wr_data),
        .clear   (w_clear),
        .rd_idx  (w_rd_idx),
        .rd_data (w_rd_data),
        .count   (w_count),
        .full    (w_full),
        .max     (w_max),
        .min     (w_min)
    );

    // Frame sequencer; every output is registered from the state it leads into.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_wr_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_data_out  <= '0;
            r_go        <= 1'b0;
            r_finish    <= 1'b0;
            r_done      <= 1'b0;
            r_send_err  <= 1'b0;
            r_exp_range <= '0;
        end else begin
            r_go       <= 1'b0;
            r_finish   <= 1'b0;
            r_done     <= 1'b0;
            r_send_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.send && w_has_data) begin
                        r_state    <= GO;
                        r_busy     <= 1'b1;
                        r_go       <= 1'b1;
                        r_data_out <= '0;
                        r_wr_ready <= 1'b0;
                    end else begin
                        r_send_err <= bus.send;
                        r_wr_ready <= !w_full && !w_fill_to_full;
                    end
                end
                GO: begin
                    r_state    <= STREAM;
                    r_idx      <= '0;
                    r_data_out <= w_rd_data;
                    r_finish   <= w_next_is_last;
                    if (w_next_is_last) begin
                        r_exp_range <= w_range;
                    end
                end
                STREAM: begin
                    if (w_idx_is_last) begin
                        r_state    <= GUARD;
                        r_data_out <= '0;
                        r_done     <= 1'b1;
                    end else begin
                        r_idx      <= w_rd_idx;
                        r_data_out <= w_rd_data;
                        r_finish   <= w_next_is_last;
                        if (w_next_is_last) begin
                            r_exp_range <= w_range;
                        end
                    end
                end
                GUARD: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_wr_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready  = r_wr_ready;
    assign bus.busy      = r_busy;
    assign bus.data_out  = r_data_out;
    assign bus.go        = r_go;
    assign bus.finish    = r_finish;
    assign bus.done      = r_done;
    assign bus.send_err  = r_send_err;
    assign bus.exp_range = r_exp_range;
endmodule
